// File: rtl/ysyx_25040109_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller: state encodings,
// response codes, reset PC and the buffered fetch word layout.
package ysyx_25040109_fetch_ctrl_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RESP_W = 2;

   localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 32'h8000_0000;
   localparam logic [XLEN-1:0]   INST_BYTES       = 32'd4;
   localparam logic [RESP_W-1:0] RESP_OKAY        = 2'b00;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic            fault;
      logic [XLEN-1:0] data;
   } fetch_word_t;

   function automatic logic is_fault(input logic [RESP_W-1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/ysyx_25040109_fetch_buf.sv
// Load-enabled holding register for one returned instruction word plus its
// fault flag, cleared synchronously.
module ysyx_25040109_fetch_buf
   import ysyx_25040109_fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        load,
   input  fetch_word_t d,
   output fetch_word_t q
);

   always_ff @(posedge clk) begin
      if (clr)       q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/ysyx_25040109_fetch_ctrl.sv
// Serial instruction fetch controller: owns the PC, issues one read at a time,
// buffers the response and offers it to the IFU; redirects flush and re-steer.
module ysyx_25040109_fetch_ctrl
   import ysyx_25040109_fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              arvalid,
   output logic [XLEN-1:0]   araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [XLEN-1:0]   rdata,
   input  logic [RESP_W-1:0] rresp,
   output logic              rready,
   output logic              inst_valid,
   output logic [XLEN-1:0]   inst_rdata,
   output logic [XLEN-1:0]   inst_pc,
   output logic              inst_fault,
   input  logic              inst_ready
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redir_tgt;
   logic            redir_pend;
   logic            arvalid_q;

   logic            take_redir_c;
   logic [XLEN-1:0] redir_eff_c;
   logic            buf_load_c;
   fetch_word_t     buf_d;
   fetch_word_t     buf_q;

   // A redirect arriving in the same cycle as the response counts as pending.
   assign take_redir_c = redir_pend | redirect_valid;
   assign redir_eff_c  = redirect_valid ? redirect_pc : redir_tgt;
   assign buf_load_c   = (state == ST_WAIT) && rvalid && !take_redir_c;
   assign buf_d        = '{fault: is_fault(rresp), data: rdata};

   ysyx_25040109_fetch_buf u_buf (
      .clk  (clk),
      .clr  (rst),
      .load (buf_load_c),
      .d    (buf_d),
      .q    (buf_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         redir_tgt  <= '0;
         redir_pend <= 1'b0;
         arvalid_q  <= 1'b0;
      end else begin
         case (state)
            ST_REQ: begin
               // The request is never retracted; a redirect only marks it stale.
               if (redirect_valid) begin
                  redir_pend <= 1'b1;
                  redir_tgt  <= redirect_pc;
               end
               if (arvalid_q && arready) begin
                  arvalid_q <= 1'b0;
                  state     <= ST_WAIT;
               end else begin
                  arvalid_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (rvalid) begin
                  if (take_redir_c) begin
                     pc         <= redir_eff_c;
                     redir_pend <= 1'b0;
                     arvalid_q  <= 1'b1;
                     state      <= ST_REQ;
                  end else begin
                     state <= ST_HOLD;
                  end
               end else if (redirect_valid) begin
                  redir_pend <= 1'b1;
                  redir_tgt  <= redirect_pc;
               end
            end
            ST_HOLD: begin
               if (redirect_valid) begin
                  pc        <= redirect_pc;
                  arvalid_q <= 1'b1;
                  state     <= ST_REQ;
               end else if (inst_ready) begin
                  pc        <= pc + INST_BYTES;
                  arvalid_q <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            default: state <= ST_REQ;
         endcase
      end
   end

   assign arvalid    = arvalid_q;
   assign araddr     = pc;
   assign rready     = (state == ST_WAIT);
   assign inst_valid = (state == ST_HOLD);
   assign inst_rdata = buf_q.data;
   assign inst_fault = buf_q.fault;
   assign inst_pc    = pc;

endmodule
